// File: rtl/lane_char_engine.sv
// Falling-character game engine: per-lane char/y/speed storage, spawn, per-frame movement,
// sequential key-match scan with scoring, and the IDLE/PLAY/OVER game state.
module lane_char_engine #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned LANE_AW = 3,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned SPD_W   = 3,
  parameter int unsigned BOTTOM  = 480,
  parameter int unsigned SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [LANE_AW-1:0] spawn_lane,
  input  logic [7:0]         spawn_char,
  input  logic [SPD_W-1:0]   spawn_speed,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [7:0]         key_char,
  output logic               hit,
  output logic               miss,
  input  logic [LANE_AW-1:0] rd_lane,
  output logic               rd_active,
  output logic [7:0]         rd_char,
  output logic [Y_W-1:0]     rd_y,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               gameover
);

  localparam int unsigned CNT_W = LANE_AW + 2;
  localparam logic [CNT_W-1:0] CNT_RES = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(LANES + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

  state_t state_q, state_nx;

  logic [LANES-1:0]   active_q;
  logic [7:0]         chr_q [LANES];
  logic [Y_W-1:0]     y_q   [LANES];
  logic [SPD_W-1:0]   spd_q [LANES];
  logic [Y_W-1:0]     y_mv  [LANES];

  logic               scanning, pending, best_valid;
  logic [CNT_W-1:0]   scan_cnt;
  logic [LANE_AW-1:0] scan_lane, best_idx;
  logic [Y_W-1:0]     best_y;
  logic [7:0]         key_q;

  logic over_c, do_move, key_acc, spawn_acc, scan_end, start_play;

  assign scan_lane = scan_cnt[LANE_AW-1:0];
  assign state     = state_q;

  // Candidate positions after one frame of movement
  always_comb begin
    over_c = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      y_mv[i] = y_q[i] + Y_W'(spd_q[i]);
      if (active_q[i] && (y_mv[i] >= Y_W'(BOTTOM))) over_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gameover <= 1'b0;
    end else begin
      state_q  <= state_nx;
      gameover <= (state_nx == S_OVER);
    end
  end

  // Next state plus handshake strobes; a tick coinciding with key acceptance is deferred
  always_comb begin
    state_nx    = state_q;
    key_ready   = (state_q == S_PLAY) && !scanning;
    spawn_ready = (state_q == S_PLAY) && !scanning && !active_q[spawn_lane];
    key_acc     = key_valid && key_ready;
    spawn_acc   = spawn_valid && spawn_ready;
    scan_end    = scanning && (scan_cnt == CNT_END);
    start_play  = start && (state_q != S_PLAY);
    do_move     = (state_q == S_PLAY) &&
                  ((frame_tick && !scanning && !key_acc) || (scan_end && (pending || frame_tick)));
    case (state_q)
      S_IDLE:  if (start) state_nx = S_PLAY;
      S_PLAY:  if (do_move && over_c) state_nx = S_OVER;
      S_OVER:  if (start) state_nx = S_PLAY;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= '0;
      scanning   <= 1'b0;
      pending    <= 1'b0;
      best_valid <= 1'b0;
      scan_cnt   <= '0;
      best_idx   <= '0;
      best_y     <= '0;
      key_q      <= '0;
      score      <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      rd_active  <= 1'b0;
      rd_char    <= '0;
      rd_y       <= '0;
      for (int i = 0; i < int'(LANES); i++) begin
        chr_q[i] <= '0;
        y_q[i]   <= '0;
        spd_q[i] <= '0;
      end
    end else begin
      hit       <= 1'b0;
      miss      <= 1'b0;
      rd_active <= active_q[rd_lane];
      rd_char   <= chr_q[rd_lane];
      rd_y      <= y_q[rd_lane];
      if (start_play) begin
        active_q <= '0;
        score    <= '0;
        pending  <= 1'b0;
        scanning <= 1'b0;
        scan_cnt <= '0;
        for (int i = 0; i < int'(LANES); i++) begin
          chr_q[i] <= '0;
          y_q[i]   <= '0;
          spd_q[i] <= '0;
        end
      end else if (state_q == S_PLAY) begin
        if (key_acc) begin
          scanning   <= 1'b1;
          scan_cnt   <= '0;
          key_q      <= key_char;
          best_valid <= 1'b0;
          pending    <= frame_tick;
        end else if (scanning) begin
          scan_cnt <= scan_cnt + CNT_W'(1);
          if (frame_tick) pending <= 1'b1;
          if (scan_cnt < CNT_RES) begin
            // Strict compare keeps the lower index on equal y
            if (active_q[scan_lane] && (chr_q[scan_lane] == key_q) &&
                (!best_valid || (y_q[scan_lane] > best_y))) begin
              best_valid <= 1'b1;
              best_idx   <= scan_lane;
              best_y     <= y_q[scan_lane];
            end
          end else if (scan_cnt == CNT_RES) begin
            if (best_valid) begin
              active_q[best_idx] <= 1'b0;
              hit                <= 1'b1;
              if (score != '1) score <= score + SCORE_W'(1);
            end else begin
              miss <= 1'b1;
            end
          end else begin
            scanning <= 1'b0;
            pending  <= 1'b0;
            scan_cnt <= '0;
          end
        end
        if (do_move) begin
          for (int i = 0; i < int'(LANES); i++)
            if (active_q[i]) y_q[i] <= y_mv[i];
        end
        if (spawn_acc) begin
          active_q[spawn_lane] <= 1'b1;
          y_q[spawn_lane]      <= '0;
          chr_q[spawn_lane]    <= spawn_char;
          spd_q[spawn_lane]    <= spawn_speed;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_char_engine.sv
// Directed bench for lane_char_engine: a lane model predicts scan outcomes, which are
// queued at key acceptance and compared when the hit/miss pulse appears.
module tb_lane_char_engine;
  localparam int LANES = 8;

  logic       clk = 1'b0;
  logic       rst_n, start, frame_tick, spawn_valid, spawn_ready, key_valid, key_ready;
  logic [2:0] spawn_lane, rd_lane;
  logic [7:0] spawn_char, key_char, rd_char;
  logic [2:0] spawn_speed;
  logic       hit, miss, rd_active, gameover;
  logic [9:0] rd_y;
  logic [7:0] score;
  logic [1:0] state;

  lane_char_engine #(.LANES(8), .LANE_AW(3), .Y_W(10), .SPD_W(3), .BOTTOM(480), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_lane(spawn_lane),
    .spawn_char(spawn_char), .spawn_speed(spawn_speed),
    .key_valid(key_valid), .key_ready(key_ready), .key_char(key_char),
    .hit(hit), .miss(miss), .rd_lane(rd_lane), .rd_active(rd_active),
    .rd_char(rd_char), .rd_y(rd_y), .score(score), .state(state), .gameover(gameover)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic hit; logic [31:0] lane; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  bit        m_act [LANES];
  int        m_y   [LANES];
  int        m_spd [LANES];
  logic [7:0] m_chr [LANES];
  int        m_score, m_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < LANES; i++) begin
      m_act[i] = 1'b0; m_y[i] = 0; m_spd[i] = 0; m_chr[i] = 8'h00;
    end
    m_score = 0;
  endtask

  task automatic m_move();
    bit ov = 1'b0;
    if (m_state != 1) return;
    for (int i = 0; i < LANES; i++)
      if (m_act[i]) begin
        m_y[i] += m_spd[i];
        if (m_y[i] >= 480) ov = 1'b1;
      end
    if (ov) m_state = 2;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
    m_clear(); m_state = 1;
    chk("start_state", 32'(state), 32'(m_state));
    chk("start_score", 32'(score), 0);
    chk("start_gameover", 32'(gameover), 0);
  endtask

  task automatic do_spawn(input int lane, input logic [7:0] c, input int spd);
    spawn_lane = 3'(lane); spawn_char = c; spawn_speed = 3'(spd); spawn_valid = 1'b1;
    #1;
    chk("spawn_ready", 32'(spawn_ready), 1);
    cyc();
    spawn_valid = 1'b0;
    m_act[lane] = 1'b1; m_y[lane] = 0; m_chr[lane] = c; m_spd[lane] = spd;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    m_move();
    chk("tick_state", 32'(state), 32'(m_state));
    chk("tick_gameover", 32'(gameover), 32'(m_state == 2));
  endtask

  task automatic check_lanes();
    for (int i = 0; i < LANES; i++) begin
      rd_lane = 3'(i); cyc();
      chk($sformatf("rd_active%0d", i), 32'(rd_active), 32'(m_act[i]));
      if (m_act[i]) begin
        chk($sformatf("rd_y%0d", i), 32'(rd_y), 32'(m_y[i]));
        chk($sformatf("rd_char%0d", i), 32'(rd_char), 32'(m_chr[i]));
      end
    end
  endtask

  // mid=1 fires two ticks and a refused spawn while the scan runs
  task automatic do_key(input logic [7:0] c, input bit mid);
    exp_t e;
    int best = -1;
    int lat = 0;
    for (int i = 0; i < LANES; i++)
      if (m_act[i] && m_chr[i] == c && (best < 0 || m_y[i] > m_y[best])) best = i;
    e.hit = (best >= 0);
    e.lane = 32'(best);
    sb.push_back(e);
    chk("key_ready_pre", 32'(key_ready), 1);
    key_char = c; key_valid = 1'b1; cyc(); key_valid = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (mid) begin
        frame_tick = (k == 2 || k == 4);
        if (k == 3) begin
          spawn_lane = 3'd6; spawn_valid = 1'b1; #1;
          chk("spawn_ready_scan", 32'(spawn_ready), 0);
        end
      end
      cyc();
      frame_tick = 1'b0; spawn_valid = 1'b0;
      if (hit || miss) lat = k;
    end
    chk("pulse_latency", 32'(lat), LANES + 1);
    e = sb.pop_front();
    chk("hit", 32'(hit), 32'(e.hit));
    chk("miss", 32'(miss), 32'(!e.hit));
    if (e.hit) begin
      m_act[e.lane] = 1'b0;
      if (m_score < 255) m_score++;
    end
    chk("score", 32'(score), 32'(m_score));
    if (mid) m_move();
    cyc();
    chk("key_ready_post", 32'(key_ready), 1);
    chk("pulse_width", 32'(hit | miss), 0);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0; spawn_valid = 1'b0; spawn_lane = '0;
    spawn_char = '0; spawn_speed = '0; key_valid = 1'b0; key_char = '0; rd_lane = '0;
    m_clear(); m_state = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_gameover", 32'(gameover), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_key_ready", 32'(key_ready), 0);
    chk("rst_spawn_ready", 32'(spawn_ready), 0);
    chk("rst_hitmiss", 32'(hit | miss), 0);
    chk("rst_rd", 32'({rd_active, rd_char, rd_y}), 0);

    // Basic fall
    do_start();
    do_spawn(2, "A", 3);
    repeat (5) do_tick();
    check_lanes();
    chk("t1_score", 32'(score), 0);

    // Deepest candidate wins
    do_spawn(1, "B", 3);
    do_spawn(4, "B", 7);
    repeat (3) do_tick();
    check_lanes();
    do_key("B", 1'b0);
    check_lanes();

    // Tie goes to the lower index, then a miss
    do_spawn(3, "C", 2);
    do_spawn(5, "C", 2);
    repeat (2) do_tick();
    do_key("C", 1'b0);
    check_lanes();
    do_key("Z", 1'b0);

    // Clear the field, then reach the bottom
    do_key("B", 1'b0);
    do_key("A", 1'b0);
    do_key("C", 1'b0);
    do_spawn(0, "0", 7);
    repeat (68) do_tick();
    check_lanes();
    do_tick();
    check_lanes();
    do_tick();
    do_start();
    check_lanes();

    // Ticks during a scan collapse into one move after the pulse
    do_spawn(3, "D", 5);
    do_spawn(1, "E", 2);
    do_key("D", 1'b1);
    check_lanes();

    // Score saturation
    while (m_score < 255) begin
      do_spawn(7, "x", 0);
      do_key("x", 1'b0);
    end
    do_spawn(7, "x", 0);
    do_key("x", 1'b0);
    chk("score_sat", 32'(score), 255);

    // Reset in the middle of a scan
    key_char = "E"; key_valid = 1'b1; cyc(); key_valid = 1'b0;
    cyc(); cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_gameover", 32'(gameover), 0);
    chk("mid_rst_hitmiss", 32'(hit | miss), 0);
    chk("mid_rst_ready", 32'({key_ready, spawn_ready}), 0);
    chk("mid_rst_rd", 32'({rd_active, rd_char, rd_y}), 0);
    cyc(); cyc();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < LANES + 4; k++) begin
      cyc();
      if (hit || miss) pulses++;
    end
    chk("mid_rst_no_pulse", 32'(pulses), 0);
    rd_lane = 3'd1; cyc();
    chk("mid_rst_lane1", 32'({rd_active, rd_y}), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
